// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready requesters share one combinational ALU; the result of
// each accepted operation sits in a one-entry registered slot owned by its requester.

module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    input  logic        req_mod_0,
    input  logic        req_mod_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid and payload until accepted; ready may look at valid, never
    // the reverse. A response stays valid and stable until its owner raises rsp_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_rsp_data;
    logic        r_last_grant;

    logic        w_slot_free;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept0;
    logic        w_accept1;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [2:0]  w_alu_op;
    logic        w_alu_mod;
    logic [31:0] w_alu_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_slot_free = 1'b0;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_accept0   = 1'b0;
        w_accept1   = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            IDLE:    w_slot_free = 1'b1;
            HOLD0:   w_slot_free = rsp_ready_0;
            HOLD1:   w_slot_free = rsp_ready_1;
            default: w_slot_free = 1'b0;
        endcase

        // Requester 1 wins a conflict only in round-robin mode after a requester-0 grant.
        w_grant1  = req_valid_1 && (!req_valid_0 || (!FIXED_PRIO && !r_last_grant));
        w_grant0  = req_valid_0 && !w_grant1;
        w_accept0 = w_grant0 && w_slot_free && !rst;
        w_accept1 = w_grant1 && w_slot_free && !rst;

        case (r_state)
            HOLD0:   if (rsp_ready_0) w_state_nxt = IDLE;
            HOLD1:   if (rsp_ready_1) w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
        endcase
        if (w_accept0) begin
            w_state_nxt = HOLD0;
        end else if (w_accept1) begin
            w_state_nxt = HOLD1;
        end
    end

    assign req_ready_0 = w_accept0;
    assign req_ready_1 = w_accept1;
    assign rsp_valid_0 = (r_state == HOLD0);
    assign rsp_valid_1 = (r_state == HOLD1);
    assign rsp_data    = r_rsp_data;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

    assign w_alu_a   = w_grant1 ? req_a_1   : req_a_0;
    assign w_alu_b   = w_grant1 ? req_b_1   : req_b_0;
    assign w_alu_op  = w_grant1 ? req_op_1  : req_op_0;
    assign w_alu_mod = w_grant1 ? req_mod_1 : req_mod_0;

    alu u_alu (
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .i_op  (w_alu_op),
        .i_mod (w_alu_mod),
        .o_y   (w_alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data   <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept0 || w_accept1) begin
            r_rsp_data   <= w_alu_y;
            r_last_grant <= w_accept1;
        end
    end

endmodule

// Combinational integer ALU; opcodes follow the RV32I funct3 encoding.
module alu (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    input  logic        i_mod,
    output logic [31:0] o_y
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            3'b000:  o_y = i_mod ? (i_a - i_b) : (i_a + i_b);
            3'b001:  o_y = i_a << w_shamt;
            3'b010:  o_y = {31'b0, ($signed(i_a) < $signed(i_b))};
            3'b011:  o_y = {31'b0, (i_a < i_b)};
            3'b100:  o_y = i_a ^ i_b;
            3'b101:  o_y = i_mod ? 32'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            3'b110:  o_y = i_a | i_b;
            3'b111:  o_y = i_a & i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table through both requesters, a response scoreboard,
// and hand sequences for conflict, backpressure, wrong-owner ready and reset mid-hold.

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_a   [2];
    logic [31:0] req_b   [2];
    logic [2:0]  req_op  [2];
    logic        req_mod [2];
    logic [1:0]  rsp_ready;

    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [31:0] rsp_data;
    wire         busy;
    wire  [1:0]  dbg_state;

    wire  [1:0]  fp_req_ready;
    wire  [1:0]  fp_rsp_valid;
    wire  [31:0] fp_rsp_data;
    wire         fp_busy;
    wire  [1:0]  fp_dbg_state;

    int total;
    int bad;

    logic [32:0] exp_q [$];
    logic [32:0] sb_front;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        mod;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid[0]),
        .req_valid_1 (req_valid[1]),
        .req_ready_0 (req_ready[0]),
        .req_ready_1 (req_ready[1]),
        .req_a_0     (req_a[0]),
        .req_a_1     (req_a[1]),
        .req_b_0     (req_b[0]),
        .req_b_1     (req_b[1]),
        .req_op_0    (req_op[0]),
        .req_op_1    (req_op[1]),
        .req_mod_0   (req_mod[0]),
        .req_mod_1   (req_mod[1]),
        .rsp_valid_0 (rsp_valid[0]),
        .rsp_valid_1 (rsp_valid[1]),
        .rsp_ready_0 (rsp_ready[0]),
        .rsp_ready_1 (rsp_ready[1]),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid[0]),
        .req_valid_1 (req_valid[1]),
        .req_ready_0 (fp_req_ready[0]),
        .req_ready_1 (fp_req_ready[1]),
        .req_a_0     (req_a[0]),
        .req_a_1     (req_a[1]),
        .req_b_0     (req_b[0]),
        .req_b_1     (req_b[1]),
        .req_op_0    (req_op[0]),
        .req_op_1    (req_op[1]),
        .req_mod_0   (req_mod[0]),
        .req_mod_1   (req_mod[1]),
        .rsp_valid_0 (fp_rsp_valid[0]),
        .rsp_valid_1 (fp_rsp_valid[1]),
        .rsp_ready_0 (rsp_ready[0]),
        .rsp_ready_1 (rsp_ready[1]),
        .rsp_data    (fp_rsp_data),
        .busy        (fp_busy),
        .o_dbg_state (fp_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic mod);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            3'd0: return mod ? a + (~b) + 32'd1 : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return mod ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rsp_valid[0] && rsp_valid[1]) begin
            check("sb_both_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            if (rsp_valid[k]) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    sb_front = exp_q[0];
                    check("sb_data", rsp_data, sb_front[31:0]);
                    check("sb_owner", 32'(k), 32'(sb_front[32]));
                    if (rsp_ready[k]) void'(exp_q.pop_front());
                end
            end
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    exp_q.push_back({1'(k), alu_model(req_a[k], req_b[k], req_op[k], req_mod[k])});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic mod);
        req_a[k]   = a;
        req_b[k]   = b;
        req_op[k]  = op;
        req_mod[k] = mod;
    endtask

    task automatic rand_req(input int k);
        set_req(k, $urandom(), $urandom(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    // Single operation with the owner always ready: accept, one-cycle result, back to idle.
    task automatic do_op(input int k, input vec_t v);
        int n;
        set_req(k, v.a, v.b, v.op, v.mod);
        req_valid[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("op_accept", 32'(req_ready[k]), 32'd1);
        tick();
        req_valid[k] = 1'b0;
        @(negedge clk);
        check("op_rsp_valid", 32'(rsp_valid[k]), 32'd1);
        check("op_rsp_other", 32'(rsp_valid[1-k]), 32'd0);
        check("op_rsp_data", rsp_data, v.exp);
        tick();
        @(negedge clk);
        check("op_idle_after", 32'(busy), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 2; k++) set_req(k, '0, '0, 3'd0, 1'b0);

        vecs[0]  = '{a: 32'd5,          b: 32'd7,  op: 3'd0, mod: 1'b0, exp: 32'd12};
        vecs[1]  = '{a: 32'd0,          b: 32'd1,  op: 3'd0, mod: 1'b1, exp: 32'hFFFF_FFFF};
        vecs[2]  = '{a: 32'h8000_0000,  b: 32'd4,  op: 3'd5, mod: 1'b1, exp: 32'hF800_0000};
        vecs[3]  = '{a: 32'h8000_0000,  b: 32'd4,  op: 3'd5, mod: 1'b0, exp: 32'h0800_0000};
        vecs[4]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,  op: 3'd2, mod: 1'b0, exp: 32'd1};
        vecs[5]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,  op: 3'd3, mod: 1'b0, exp: 32'd0};
        vecs[6]  = '{a: 32'h0000_0001,  b: 32'd33, op: 3'd1, mod: 1'b0, exp: 32'd2};
        vecs[7]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,  op: 3'd0, mod: 1'b0, exp: 32'd0};
        vecs[8]  = '{a: 32'hF0F0_1234,  b: 32'h0FF0_FFFF, op: 3'd4, mod: 1'b0, exp: 32'hFF00_EDCB};
        vecs[9]  = '{a: 32'hF000_000F,  b: 32'h0000_0FF0, op: 3'd6, mod: 1'b0, exp: 32'hF000_0FFF};
        vecs[10] = '{a: 32'hF0F0_F0F0,  b: 32'h3C3C_3C3C, op: 3'd7, mod: 1'b0, exp: 32'h3030_3030};
        vecs[11] = '{a: 32'd3,          b: 32'd5,  op: 3'd2, mod: 1'b0, exp: 32'd1};

        // Reset state, with a request pending that must not be accepted.
        req_valid[0] = 1'b1;
        tick();
        @(negedge clk);
        check("rst_req_ready0", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick();
        req_valid = 2'b00;
        rst = 1'b0;

        // Vector table, alternating requesters.
        for (int i = 0; i < 12; i++) begin
            do_op(i % 2, vecs[i]);
            tick();
        end

        // Conflict: both valid and always ready; RR alternates, fixed priority keeps 0.
        do_reset();
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_ready0", 32'(req_ready[0]), 32'((i % 2) == 0));
            check("rr_ready1", 32'(req_ready[1]), 32'((i % 2) == 1));
            check("fp_ready0", 32'(fp_req_ready[0]), 32'd1);
            check("fp_ready1", 32'(fp_req_ready[1]), 32'd0);
            tick();
            rand_req(i % 2);
        end
        req_valid = 2'b00;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rr_drained_busy", 32'(busy), 32'd0);
        tick();

        // Backpressure: owner 0 stalls, requester 1 waits, then drain and refill same cycle.
        set_req(0, 32'd1, 32'd1, 3'd0, 1'b0);
        rsp_ready = 2'b10;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("bp_accept0", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 32'h0000_F0F0, 32'h0000_0FF0, 3'd4, 1'b0);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_hold_data", rsp_data, 32'd2);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_ready1_blocked", 32'(req_ready[1]), 32'd0);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_ready1_refill", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("bp_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
        check("bp_rsp0_clear", 32'(rsp_valid[0]), 32'd0);
        check("bp_rsp1_data", rsp_data, 32'h0000_FF00);
        tick();

        // Wrong-owner ready while in HOLD0.
        set_req(0, 32'd3, 32'd4, 3'd0, 1'b0);
        rsp_ready = 2'b10;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("wo_accept0", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wo_state", 32'(dbg_state), 32'd1);
            check("wo_data", rsp_data, 32'd7);
            check("wo_rsp1", 32'(rsp_valid[1]), 32'd0);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("wo_idle", 32'(busy), 32'd0);
        tick();

        // Reset mid-hold: HOLD1 with 0x1234, reset with req0 pending, then a conflict.
        set_req(1, 32'h0000_1000, 32'h0000_0234, 3'd0, 1'b0);
        rsp_ready = 2'b00;
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("rm_accept1", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("rm_hold_data", rsp_data, 32'h0000_1234);
        tick();
        rst = 1'b1;
        set_req(0, 32'd9, 32'd9, 3'd0, 1'b0);
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("rm_no_accept", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        set_req(1, 32'd100, 32'd1, 3'd0, 1'b1);
        req_valid = 2'b11;
        @(negedge clk);
        check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rm_rsp_data", rsp_data, 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_conflict_ready0", 32'(req_ready[0]), 32'd1);
        check("rm_conflict_ready1", 32'(req_ready[1]), 32'd0);
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("rm_post_rsp0", 32'(rsp_valid[0]), 32'd1);
        check("rm_post_data", rsp_data, 32'd18);
        tick();
        @(negedge clk);
        check("rm_final_idle", 32'(busy), 32'd0);

        // ---------------- report ----------------
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath of the risky core between two requesters (requester 0: execute stage, requester 1: address/branch helper) using valid/ready handshakes. Grants one operation per cycle, round-robin or fixed priority, evaluates it through an internally instantiated `alu`, and holds the registered result in a one-entry response slot routed back to the granted requester.

## Interface

Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins a conflict.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_0`, `req_valid_1`  in  1  request present.
- `req_ready_0`, `req_ready_1`  out  1  request accepted this cycle when high together with valid.
- `req_a_0`, `req_a_1`  in  32  operand 1.
- `req_b_0`, `req_b_1`  in  32  operand 2.
- `req_op_0`, `req_op_1`  in  3  ALU opcode (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND).
- `req_mod_0`, `req_mod_1`  in  1  opcode modifier (SUB, SRA).
- `rsp_valid_0`, `rsp_valid_1`  out  1  result available for that requester.
- `rsp_ready_0`, `rsp_ready_1`  in  1  requester consumes result.
- `rsp_data`  out  32  result; shared bus, qualified by `rsp_valid_k`.
- `busy`  out  1  response slot occupied.

## Operation

- State machine: `IDLE` (slot empty), `HOLD0` (slot owned by requester 0), `HOLD1` (slot owned by requester 1).
- `slot_free` = `IDLE`, or `HOLDk` with `rsp_ready_k` high (drain and refill in the same cycle).
- Arbitration, combinational: if exactly one `req_valid_k`, it is granted; if both, round-robin grants the requester not granted last, and `FIXED_PRIO`=1 grants requester 0.
- `req_ready_k` = granted_k AND `slot_free` AND NOT `rst`. At most one `req_ready_k` is high in any cycle.
- `req_ready_k` may depend on `req_valid_*` and `rsp_ready_*`. A requester holds valid and its payload stable until accepted; requesters never make valid depend on ready.
- On acceptance of requester k: drive the granted a/b/op/mod into `alu`, register the output into `rsp_data`, go to `HOLDk`, and set `last_grant` to k.
- `HOLDk`: `rsp_valid_k`=1 and `rsp_data` stable until `rsp_ready_k`. On `rsp_ready_k` with no new acceptance, go to `IDLE`. On `rsp_ready_k` with an acceptance of requester j, go to `HOLDj` with new data.
- While in `HOLDk`, `rsp_ready_j` for j≠k is ignored.
- ALU semantics are exactly those of `alu`:
  - 32-bit wraparound add/sub.
  - Shift amount is `b[4:0]`.
  - SLT is signed; SLTU is unsigned.
  - Results are 0/1 zero-extended.
- `busy` = state ≠ `IDLE`.

## Timing

- Reset values:
  - state `IDLE`
  - `rsp_valid_0`=`rsp_valid_1`=0
  - `rsp_data`=0
  - `last_grant`=1, so requester 0 wins the first conflict
  - `busy`=0
  - `req_ready_*`=0 while `rst` is high
- Latency: accepted at edge N, so `rsp_valid_k`=1 and the result are visible after edge N (cycle N+1).
- Throughput: one operation per cycle when the owner asserts `rsp_ready` continuously.
- With both requesters continuously valid and always ready, grants alternate 0,1,0,1 from reset.
- Reset mid-operation: `rst` high at edge N discards the held result and any same-cycle acceptance. Outputs return to reset values after edge N; no response for the discarded operation ever appears.
- Starvation bound in round-robin mode: a continuously valid requester is accepted within 2 slot-free cycles.

## Test plan

- Single ADD: req0 a=5, b=7, op=000, mod=0 with `rsp_ready_0`=1. Required: `req_ready_0` high in cycle 0; next cycle `rsp_valid_0`=1, `rsp_data`=12, `rsp_valid_1`=0; `IDLE` after.
- Arithmetic corners: SUB 0−1 gives 0xFFFFFFFF; SRA 0x80000000 by 4 gives 0xF8000000; SRL same gives 0x08000000; SLT 0xFFFFFFFF<1 gives 1; SLTU same gives 0; SLL by b=33 shifts by 1.
- Conflict round-robin: both requesters valid every cycle, both rsp_ready=1. Required: acceptance order 0,1,0,1 after reset, each result on the correct `rsp_valid_k`. With `FIXED_PRIO`=1: requester 0 is accepted every cycle and requester 1 never.
- Backpressure: req0 ADD 1+1 accepted, `rsp_ready_0`=0 for 3 cycles while req1 is valid. Required: `rsp_data`=2 held, `busy`=1, `req_ready_1`=0. When `rsp_ready_0` rises, req1 is accepted the same cycle and its result appears the next cycle.
- Wrong-owner ready: in `HOLD0`, `rsp_ready_1`=1 and `rsp_ready_0`=0. Required: state and data unchanged.
- Reset mid-hold: in `HOLD1` with data 0x1234, assert `rst` for one cycle with req0 valid. Required: next cycle all rsp_valid=0, `rsp_data`=0, `busy`=0, no acceptance during reset. The first post-reset conflict grants requester 0.
